cdb_arbiter: RTL and testbench
==============================

CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_RS, default 4, giving the number of reservation stations sharing the common data bus (legal 2..16).
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, giving the broadcast value width.
REQ-003 The block SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, synchronous and active-low: the block resets at a clk rising edge where rst is 0.
REQ-005 The block SHALL have port ready_i  input  NUM_RS  per-RS retirement-ready request; bit i corresponds to RS i.
REQ-006 The block SHALL have port value_i  input  NUM_RS x DATA_WIDTH  per-RS result value, valid while ready_i[i] is 1.
REQ-007 The block SHALL have port stall_i  input  1  back-end stall; blocks new grants.
REQ-008 The block SHALL have port flush_i  input  1  pipeline flush; cancels arbitration state.
REQ-009 The block SHALL have port retire_o  output  NUM_RS  one-hot retire strobe to the granted RS, or all zero.
REQ-010 The block SHALL have port bcast_en_o  output  1  CDB broadcast valid.
REQ-011 The block SHALL have port bcast_data_o  output  DATA_WIDTH  CDB broadcast value.
REQ-012 The block SHALL have port bcast_rs_o  output  e_functional_unit  CDB broadcast source; RS i is encoded as e_functional_unit'(i).

Function
REQ-013 Arbitration SHALL be registered: requests sampled in cycle N produce retire_o, bcast_en_o, bcast_data_o and bcast_rs_o in cycle N+1, one cycle of latency.
REQ-014 The eligible set in cycle N SHALL be ready_i & ~retire_o, so the RS being retired in cycle N cannot be re-granted in N+1.
REQ-015 When eligible is non-zero, stall_i is 0 and flush_i is 0, the block SHALL register: winner w, retire_o = one-hot(w), bcast_en_o = 1, bcast_data_o = value_i[w], bcast_rs_o = w.
REQ-016 Otherwise the block SHALL register retire_o = 0 and bcast_en_o = 0, while bcast_data_o and bcast_rs_o hold their previous values.
REQ-017 At all times the outputs SHALL satisfy: retire_o equals one-hot(bcast_rs_o) when bcast_en_o is 1, and 0 when bcast_en_o is 0; at most one bit of retire_o is set.
REQ-018 The winner SHALL be the first eligible index found scanning upward from pointer ptr and wrapping from NUM_RS-1 to 0.
REQ-019 After a grant to w, ptr SHALL become (w+1) mod NUM_RS; ptr SHALL be unchanged in any cycle without a grant.
REQ-020 Stall: a grant already on the outputs SHALL complete in its cycle; while stall_i is 1, no new grant is registered.
REQ-021 Flush: flush_i in cycle N SHALL give retire_o = 0 and bcast_en_o = 0 in N+1 and set ptr to 0; flush SHALL take priority over stall and over requests.
REQ-022 A ready_i bit that is 0 in the arbitration cycle SHALL NOT be granted, even if it was 1 earlier.
REQ-023 The block SHALL be a single state: no state machine beyond ptr and the output registers; throughput SHALL be one broadcast per cycle when two or more RS alternate requests.

Reset
REQ-024 At reset the block SHALL set retire_o = 0, bcast_en_o = 0, bcast_data_o = 0, bcast_rs_o = e_functional_unit'(0) and ptr = 0.
REQ-025 Reset asserted mid-operation SHALL drop any grant pending on the outputs in the following cycle; no partial broadcast is emitted.

Configuration
REQ-026 When macro CDB_ROUND_ROBIN_EN is defined, the block SHALL use the round-robin selection of REQ-018/019.
REQ-027 When CDB_ROUND_ROBIN_EN is undefined, the block SHALL use fixed priority with the lowest eligible index winning; ptr SHALL be absent and REQ-019/021 pointer effects SHALL not apply.

Verification
REQ-028 Reset, then ready_i = 4'b0100 with value_i[2] = 32'hDEAD_BEEF: next cycle retire_o = 4'b0100, bcast_en_o = 1, bcast_data_o = 32'hDEADBEEF, bcast_rs_o = 2; the following cycle bcast_en_o = 0.
REQ-029 With the macro defined, ready_i = 4'b1111 held: the grant order SHALL be 0, 1, 2, 3, 0 with bcast_en_o continuously 1; without the macro the grant order SHALL be 0, 1, 0, 1 (masking per REQ-014).
REQ-030 ready_i = 4'b0011 with stall_i = 1 for 3 cycles: no grants during the stall, and the first grant is RS 0 one cycle after stall_i falls.
REQ-031 Grant RS 1 (ptr = 2), then flush_i = 1 with ready_i = 4'b1111: next cycle bcast_en_o = 0; after flush_i falls, the first grant is RS 0.
REQ-032 rst = 0 in the cycle a grant is registered: next cycle retire_o = 0, bcast_en_o = 0, bcast_data_o = 0; a property check SHALL hold that retire_o is one-hot or zero and matches bcast_rs_o throughout.

Source files
------------

// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: picks one ready reservation station per cycle and registers its broadcast.
// Optional macro CDB_ROUND_ROBIN_EN selects round-robin arbitration; fixed lowest-index priority otherwise.

package cdb_arbiter_pkg;

    typedef enum logic [3:0] {
        FU_RS0  = 4'd0,
        FU_RS1  = 4'd1,
        FU_RS2  = 4'd2,
        FU_RS3  = 4'd3,
        FU_RS4  = 4'd4,
        FU_RS5  = 4'd5,
        FU_RS6  = 4'd6,
        FU_RS7  = 4'd7,
        FU_RS8  = 4'd8,
        FU_RS9  = 4'd9,
        FU_RS10 = 4'd10,
        FU_RS11 = 4'd11,
        FU_RS12 = 4'd12,
        FU_RS13 = 4'd13,
        FU_RS14 = 4'd14,
        FU_RS15 = 4'd15
    } e_functional_unit;

endpackage

module cdb_arbiter #(
    parameter int NUM_RS     = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [NUM_RS-1:0]                      ready_i,
    input  logic [NUM_RS-1:0][DATA_WIDTH-1:0]      value_i,
    input  logic                                   stall_i,
    input  logic                                   flush_i,
    output logic [NUM_RS-1:0]                      retire_o,
    output logic                                   bcast_en_o,
    output logic [DATA_WIDTH-1:0]                  bcast_data_o,
    output cdb_arbiter_pkg::e_functional_unit      bcast_rs_o
);

    import cdb_arbiter_pkg::*;

    localparam int PTR_W = (NUM_RS > 1) ? $clog2(NUM_RS) : 1;
    localparam logic [NUM_RS-1:0] ONE_HOT0 = {{(NUM_RS-1){1'b0}}, 1'b1};

    logic [NUM_RS-1:0]     retire_q,     retire_d;
    logic                  bcast_en_q,   bcast_en_d;
    logic [DATA_WIDTH-1:0] bcast_data_q, bcast_data_d;
    e_functional_unit      bcast_rs_q,   bcast_rs_d;

    logic [NUM_RS-1:0]     eligible_s;
    logic                  win_found_s;
    logic [PTR_W-1:0]      win_idx_s;

`ifdef CDB_ROUND_ROBIN_EN
    localparam int unsigned NRS_U = NUM_RS;

    logic [PTR_W-1:0]      ptr_q, ptr_d;

    // (base + off) mod NUM_RS for off < NUM_RS, without a divider
    function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] base,
                                                  input int unsigned      off);
        int unsigned sum;
        sum = 32'(base) + off;
        if (sum >= NRS_U) begin
            sum = sum - NRS_U;
        end else begin
            sum = sum;
        end
        return PTR_W'(sum);
    endfunction

    // Scan downward in distance so the nearest eligible index at or after ptr wins
    function automatic logic [PTR_W:0] pick_rr(input logic [NUM_RS-1:0] elig,
                                               input logic [PTR_W-1:0]  ptr);
        logic [PTR_W:0]   res;
        logic [PTR_W-1:0] idx;
        res = {1'b0, {PTR_W{1'b0}}};
        for (int k = NUM_RS - 1; k >= 0; k--) begin
            idx = wrap_add(ptr, k);
            if (elig[idx]) begin
                res = {1'b1, idx};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction
`else
    // Lowest set index wins
    function automatic logic [PTR_W:0] pick_fixed(input logic [NUM_RS-1:0] elig);
        logic [PTR_W:0] res;
        res = {1'b0, {PTR_W{1'b0}}};
        for (int i = NUM_RS - 1; i >= 0; i--) begin
            if (elig[PTR_W'(i)]) begin
                res = {1'b1, PTR_W'(i)};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction
`endif

    // Winner selection over requests not retiring this cycle
    always_comb begin
        eligible_s = ready_i & ~retire_q;
`ifdef CDB_ROUND_ROBIN_EN
        {win_found_s, win_idx_s} = pick_rr(eligible_s, ptr_q);
`else
        {win_found_s, win_idx_s} = pick_fixed(eligible_s);
`endif
    end

    // Next-state: flush beats stall beats a fresh grant; data/source hold when idle
    always_comb begin
        retire_d     = {NUM_RS{1'b0}};
        bcast_en_d   = 1'b0;
        bcast_data_d = bcast_data_q;
        bcast_rs_d   = bcast_rs_q;
`ifdef CDB_ROUND_ROBIN_EN
        ptr_d        = ptr_q;
`endif
        if (flush_i) begin
`ifdef CDB_ROUND_ROBIN_EN
            ptr_d = {PTR_W{1'b0}};
`else
            bcast_en_d = 1'b0;
`endif
        end else if (!stall_i && win_found_s) begin
            retire_d     = ONE_HOT0 << win_idx_s;
            bcast_en_d   = 1'b1;
            bcast_data_d = value_i[win_idx_s];
            bcast_rs_d   = e_functional_unit'(4'(win_idx_s));
`ifdef CDB_ROUND_ROBIN_EN
            ptr_d        = wrap_add(win_idx_s, 32'd1);
`endif
        end else begin
            bcast_en_d = 1'b0;
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            retire_q     <= {NUM_RS{1'b0}};
            bcast_en_q   <= 1'b0;
            bcast_data_q <= {DATA_WIDTH{1'b0}};
            bcast_rs_q   <= FU_RS0;
`ifdef CDB_ROUND_ROBIN_EN
            ptr_q        <= {PTR_W{1'b0}};
`endif
        end else begin
            retire_q     <= retire_d;
            bcast_en_q   <= bcast_en_d;
            bcast_data_q <= bcast_data_d;
            bcast_rs_q   <= bcast_rs_d;
`ifdef CDB_ROUND_ROBIN_EN
            ptr_q        <= ptr_d;
`endif
        end
    end

    assign retire_o     = retire_q;
    assign bcast_en_o   = bcast_en_q;
    assign bcast_data_o = bcast_data_q;
    assign bcast_rs_o   = bcast_rs_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed, table-driven bench for cdb_arbiter (NUM_RS=4, DATA_WIDTH=32); expectations follow CDB_ROUND_ROBIN_EN.

module tb_cdb_arbiter;

    logic                                  clk;
    logic                                  rst;
    logic [3:0]                            ready_i;
    logic [3:0][31:0]                      value_i;
    logic                                  stall_i;
    logic                                  flush_i;
    logic [3:0]                            retire_o;
    logic                                  bcast_en_o;
    logic [31:0]                           bcast_data_o;
    cdb_arbiter_pkg::e_functional_unit     bcast_rs_o;

    int total;
    int bad;
    logic prop_on;

    cdb_arbiter #(.NUM_RS(4), .DATA_WIDTH(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .ready_i      (ready_i),
        .value_i      (value_i),
        .stall_i      (stall_i),
        .flush_i      (flush_i),
        .retire_o     (retire_o),
        .bcast_en_o   (bcast_en_o),
        .bcast_data_o (bcast_data_o),
        .bcast_rs_o   (bcast_rs_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [3:0]  ready;
        logic        stall;
        logic        flush;
        logic [31:0] seed;
        logic        e_en;
        logic [3:0]  e_rs;
        logic [31:0] e_data;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic r, input logic [3:0] rdy, input logic st,
                                input logic fl, input logic [31:0] sd, input logic en,
                                input logic [3:0] rs, input logic [31:0] dat);
        vec_t v;
        v.rst = r; v.ready = rdy; v.stall = st; v.flush = fl; v.seed = sd;
        v.e_en = en; v.e_rs = rs; v.e_data = dat;
        return v;
    endfunction

    task automatic drive(input logic r, input logic [3:0] rdy, input logic st,
                         input logic fl, input logic [31:0] sd);
        @(negedge clk);
        rst = r; ready_i = rdy; stall_i = st; flush_i = fl;
        for (int i = 0; i < 4; i++) value_i[i] = sd + 32'(i);
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic en, input logic [3:0] rs,
                         input logic [31:0] dat);
        logic [3:0] e_ret;
        e_ret = en ? (4'b0001 << rs) : 4'b0000;
        total++;
        if (retire_o !== e_ret || bcast_en_o !== en || bcast_data_o !== dat ||
            4'(bcast_rs_o) !== rs) begin
            bad++;
            $display("FAIL %s: got retire=%b en=%b data=%h rs=%0d, want retire=%b en=%b data=%h rs=%0d",
                     name, retire_o, bcast_en_o, bcast_data_o, 4'(bcast_rs_o),
                     e_ret, en, dat, rs);
        end
    endtask

    // Output invariant: retire is one-hot-or-zero and agrees with the broadcast source
    always @(negedge clk) begin
        if (prop_on) begin
            total++;
            if (!$onehot0(retire_o) ||
                retire_o !== (bcast_en_o ? (4'b0001 << 4'(bcast_rs_o)) : 4'b0000)) begin
                bad++;
                $display("FAIL prop_onehot: retire=%b en=%b rs=%0d", retire_o, bcast_en_o,
                         4'(bcast_rs_o));
            end
        end
    end

    initial begin
        total = 0; bad = 0; prop_on = 1'b0;
        rst = 1'b0; ready_i = 4'b0000; stall_i = 1'b0; flush_i = 1'b0;
        for (int i = 0; i < 4; i++) value_i[i] = 32'h0;

        // Reset state
        drive(1'b0, 4'b1111, 1'b0, 1'b0, 32'h5555_0000);
        check("reset_a", 1'b0, 4'd0, 32'h0);
        drive(1'b0, 4'b0000, 1'b0, 1'b0, 32'h0);
        check("reset_b", 1'b0, 4'd0, 32'h0);
        prop_on = 1'b1;

        vecs.push_back(mk(1, 4'b0100, 0, 0, 32'hDEAD_BEED, 1, 4'd2, 32'hDEAD_BEEF));
        vecs.push_back(mk(1, 4'b0000, 0, 0, 32'h0,         0, 4'd2, 32'hDEAD_BEEF));
        vecs.push_back(mk(1, 4'b1111, 0, 1, 32'h0,         0, 4'd2, 32'hDEAD_BEEF));
`ifdef CDB_ROUND_ROBIN_EN
        vecs.push_back(mk(1, 4'b1111, 0, 0, 32'h1000_0000, 1, 4'd0, 32'h1000_0000));
        vecs.push_back(mk(1, 4'b1111, 0, 0, 32'h1000_0000, 1, 4'd1, 32'h1000_0001));
        vecs.push_back(mk(1, 4'b1111, 0, 0, 32'h1000_0000, 1, 4'd2, 32'h1000_0002));
        vecs.push_back(mk(1, 4'b1111, 0, 0, 32'h1000_0000, 1, 4'd3, 32'h1000_0003));
        vecs.push_back(mk(1, 4'b1111, 0, 0, 32'h1000_0000, 1, 4'd0, 32'h1000_0000));
`else
        vecs.push_back(mk(1, 4'b1111, 0, 0, 32'h1000_0000, 1, 4'd0, 32'h1000_0000));
        vecs.push_back(mk(1, 4'b1111, 0, 0, 32'h1000_0000, 1, 4'd1, 32'h1000_0001));
        vecs.push_back(mk(1, 4'b1111, 0, 0, 32'h1000_0000, 1, 4'd0, 32'h1000_0000));
        vecs.push_back(mk(1, 4'b1111, 0, 0, 32'h1000_0000, 1, 4'd1, 32'h1000_0001));
        vecs.push_back(mk(1, 4'b1111, 0, 0, 32'h1000_0000, 1, 4'd0, 32'h1000_0000));
`endif
        vecs.push_back(mk(1, 4'b0000, 0, 0, 32'h0,         0, 4'd0, 32'h1000_0000));
        vecs.push_back(mk(1, 4'b0000, 0, 1, 32'h0,         0, 4'd0, 32'h1000_0000));
        vecs.push_back(mk(1, 4'b0011, 1, 0, 32'h2000_0000, 0, 4'd0, 32'h1000_0000));
        vecs.push_back(mk(1, 4'b0011, 1, 0, 32'h2000_0000, 0, 4'd0, 32'h1000_0000));
        vecs.push_back(mk(1, 4'b0011, 1, 0, 32'h2000_0000, 0, 4'd0, 32'h1000_0000));
        vecs.push_back(mk(1, 4'b0011, 0, 0, 32'h2000_0000, 1, 4'd0, 32'h2000_0000));
        vecs.push_back(mk(1, 4'b0011, 0, 0, 32'h2000_0000, 1, 4'd1, 32'h2000_0001));
        vecs.push_back(mk(1, 4'b1111, 0, 1, 32'h3000_0000, 0, 4'd1, 32'h2000_0001));
        vecs.push_back(mk(1, 4'b1111, 0, 0, 32'h3000_0000, 1, 4'd0, 32'h3000_0000));
        vecs.push_back(mk(1, 4'b1111, 1, 1, 32'h3000_0000, 0, 4'd0, 32'h3000_0000));
        vecs.push_back(mk(1, 4'b0010, 0, 0, 32'h3000_0000, 1, 4'd1, 32'h3000_0001));
        vecs.push_back(mk(1, 4'b1000, 0, 0, 32'h3000_0000, 1, 4'd3, 32'h3000_0003));
        vecs.push_back(mk(1, 4'b0100, 0, 0, 32'h3000_0000, 1, 4'd2, 32'h3000_0002));
        vecs.push_back(mk(1, 4'b0001, 1, 0, 32'h3000_0000, 0, 4'd2, 32'h3000_0002));
        vecs.push_back(mk(1, 4'b0011, 0, 0, 32'h3000_0000, 1, 4'd0, 32'h3000_0000));

        foreach (vecs[n]) begin
            drive(vecs[n].rst, vecs[n].ready, vecs[n].stall, vecs[n].flush, vecs[n].seed);
            check($sformatf("vec%0d", n), vecs[n].e_en, vecs[n].e_rs, vecs[n].e_data);
        end

        // Reset in the cycle a grant would be registered, then over a grant on the outputs
        drive(1'b0, 4'b0010, 1'b0, 1'b0, 32'h4000_0000);
        check("rst_pending", 1'b0, 4'd0, 32'h0);
        drive(1'b1, 4'b0010, 1'b0, 1'b0, 32'h4000_0000);
        check("post_rst_grant", 1'b1, 4'd1, 32'h4000_0001);
        drive(1'b0, 4'b1111, 1'b0, 1'b0, 32'h4000_0000);
        check("rst_over_grant", 1'b0, 4'd0, 32'h0);

        prop_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
